order_tx_framer: RTL and testbench

//  Downstream of the system top's order outputs (tx_addr/tx_buysell/tx_timestamp/tx_dv).
//  - Buffers order decisions in a small FIFO.
//  - Serialises each order into a fixed 8-byte frame on a valid/ready byte stream for the exchange link MAC.
//  - Absorbs bursts of decisions while the link is back-pressured.
//  - Counts orders dropped on overflow.

---
 rtl/hft_pkg.sv | 36 +++
 rtl/order_tx_framer_if.sv | 27 ++
 rtl/order_fifo.sv | 56 +++++
 rtl/order_tx_framer.sv | 147 ++++++++++++++
 tb/tb_order_tx_framer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hft_pkg.sv
// Shared types and constants for the order path: order entry layout, frame
// geometry and the framer state encoding.
package hft_pkg;

    localparam int         ORDER_W           = 48;
    localparam int         FRAME_BYTES       = 8;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  buysell;
        logic [31:0] timestamp;
    } order_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } framer_state_t;

    typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

    // Byte 0 is the sync marker, byte 7 the XOR of the payload bytes 1..6.
    function automatic frame_t build_frame(input order_t ord, input logic [7:0] sync);
        frame_t f;
        f[0] = sync;
        f[1] = ord.addr;
        f[2] = ord.buysell;
        f[3] = ord.timestamp[31:24];
        f[4] = ord.timestamp[23:16];
        f[5] = ord.timestamp[15:8];
        f[6] = ord.timestamp[7:0];
        f[7] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6];
        return f;
    endfunction

endpackage

// File: rtl/order_tx_framer_if.sv
// Order capture inputs, framed byte stream and status of order_tx_framer.
interface order_tx_framer_if #(
    parameter int DROP_W = 16
);
    logic [7:0]        in_addr;
    logic [7:0]        in_buysell;
    logic [31:0]       in_timestamp;
    logic              in_dv;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eof;
    logic              fifo_full;
    logic [DROP_W-1:0] drop_count;
    logic              busy;

    modport master (
        output in_addr, in_buysell, in_timestamp, in_dv, out_ready,
        input  out_byte, out_valid, out_sof, out_eof, fifo_full, drop_count, busy
    );

    modport slave (
        input  in_addr, in_buysell, in_timestamp, in_dv, out_ready,
        output out_byte, out_valid, out_sof, out_eof, fifo_full, drop_count, busy
    );
endinterface

// File: rtl/order_fifo.sv
// Synchronous FIFO with registered read: rd_data is valid the cycle after rd_en.
module order_fifo
    import hft_pkg::*;
#(
    parameter int WIDTH = ORDER_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_do_rd;
    logic             w_do_wr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);
    assign rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/order_tx_framer.sv
// Buffers order decisions and serialises each into an 8-byte sync/payload/XOR
// frame on a valid/ready byte stream; counts orders lost to FIFO overflow.
module order_tx_framer
    import hft_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter int         DROP_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    order_tx_framer_if.slave  bus
);
    localparam int                IDX_W    = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    framer_state_t     r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_idx_inc;
    logic              r_fresh, w_fresh_nxt;
    frame_t            r_frame, w_frame_cur;
    logic [7:0]        r_out_byte, w_byte_nxt;
    logic              r_out_valid, w_valid_nxt;
    logic              r_out_sof, w_sof_nxt;
    logic              r_out_eof, w_eof_nxt;
    logic [DROP_W-1:0] r_drop;

    logic               w_hs;
    logic               w_load;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [ORDER_W-1:0] w_rd_data;
    order_t             w_in_order;

    assign w_in_order = '{addr: bus.in_addr, buysell: bus.in_buysell, timestamp: bus.in_timestamp};
    assign w_wr       = bus.in_dv && (!w_fifo_full || w_pop);
    assign w_drop     = bus.in_dv && !w_wr;
    assign w_hs       = r_out_valid && bus.out_ready;
    assign w_idx_inc  = r_idx + 1'b1;

    order_fifo #(
        .WIDTH (ORDER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (w_wr),
        .wr_data (w_in_order),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // Byte 0 is the constant sync marker, so it is emitted at the pop edge while
    // the FIFO read completes; the frame is built from rd_data one cycle later.
    always_comb begin
        w_frame_cur = r_fresh ? build_frame(order_t'(w_rd_data), SYNC_BYTE) : r_frame;
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_fresh_nxt = 1'b0;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_byte_nxt  = r_out_byte;
        w_valid_nxt = r_out_valid;
        w_sof_nxt   = r_out_sof;
        w_eof_nxt   = r_out_eof;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_load = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (r_idx == LAST_IDX) begin
                        if (!w_fifo_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = '0;
                            w_byte_nxt  = '0;
                            w_valid_nxt = 1'b0;
                            w_sof_nxt   = 1'b0;
                            w_eof_nxt   = 1'b0;
                        end
                    end else begin
                        w_idx_nxt  = w_idx_inc;
                        w_byte_nxt = w_frame_cur[w_idx_inc];
                        w_sof_nxt  = 1'b0;
                        w_eof_nxt  = (w_idx_inc == LAST_IDX);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_load) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_SEND;
            w_idx_nxt   = '0;
            w_fresh_nxt = 1'b1;
            w_byte_nxt  = SYNC_BYTE;
            w_valid_nxt = 1'b1;
            w_sof_nxt   = 1'b1;
            w_eof_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_fresh     <= 1'b0;
            r_frame     <= '0;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_fresh     <= w_fresh_nxt;
            r_out_byte  <= w_byte_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_sof   <= w_sof_nxt;
            r_out_eof   <= w_eof_nxt;
            if (r_fresh) begin
                r_frame <= w_frame_cur;
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign bus.out_byte   = r_out_byte;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sof    = r_out_sof;
    assign bus.out_eof    = r_out_eof;
    assign bus.fifo_full  = w_fifo_full;
    assign bus.drop_count = r_drop;
    assign bus.busy       = !w_fifo_empty || (r_state == ST_SEND);

endmodule

// File: tb/tb_order_tx_framer.sv
// Scenario bench for order_tx_framer: expected frame bytes are queued as orders
// are driven and popped by the stream monitor on every accepted byte.
module tb_order_tx_framer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    order_tx_framer_if #(.DROP_W(16)) bus ();
    order_tx_framer_if #(.DROP_W(2))  bus2 ();

    order_tx_framer #(.FIFO_DEPTH(8), .SYNC_BYTE(8'hA5), .DROP_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    order_tx_framer #(.FIFO_DEPTH(8), .SYNC_BYTE(8'hA5), .DROP_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [9:0] exp_q [$];   // {sof, eof, byte}

    logic       p_valid, p_ready, p_sof, p_eof, p_hs_noeof;
    logic [7:0] p_byte;
    logic [9:0] e;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_order(input logic [7:0] a, input logic [7:0] b, input logic [31:0] ts);
        bus.in_addr      = a;
        bus.in_buysell   = b;
        bus.in_timestamp = ts;
        bus.in_dv        = 1'b1;
    endtask

    task automatic push_order(input logic [7:0] a, input logic [7:0] b, input logic [31:0] ts);
        logic [7:0] chk;
        chk = a ^ b ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
        exp_q.push_back({2'b10, 8'hA5});
        exp_q.push_back({2'b00, a});
        exp_q.push_back({2'b00, b});
        exp_q.push_back({2'b00, ts[31:24]});
        exp_q.push_back({2'b00, ts[23:16]});
        exp_q.push_back({2'b00, ts[15:8]});
        exp_q.push_back({2'b00, ts[7:0]});
        exp_q.push_back({2'b01, chk});
    endtask

    // Stream monitor: scoreboard on accepted bytes, hold-while-stalled and
    // no-drop-mid-frame rules.
    always @(negedge clk) begin
        if (reset) begin
            p_valid    = 1'b0;
            p_ready    = 1'b0;
            p_hs_noeof = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                checks++;
                if ({bus.out_valid, bus.out_sof, bus.out_eof, bus.out_byte} !== {1'b1, p_sof, p_eof, p_byte}) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b sof=%b eof=%b byte=%h want v=1 sof=%b eof=%b byte=%h",
                             bus.out_valid, bus.out_sof, bus.out_eof, bus.out_byte, p_sof, p_eof, p_byte);
                end
            end
            if (p_hs_noeof) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_frame_valid got %b want 1", bus.out_valid);
                end
            end
            p_hs_noeof = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got %h want none", bus.out_byte);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_sof, bus.out_eof, bus.out_byte} !== e) begin
                        errors++;
                        $display("FAIL scoreboard got sof=%b eof=%b byte=%h want sof=%b eof=%b byte=%h",
                                 bus.out_sof, bus.out_eof, bus.out_byte, e[9], e[8], e[7:0]);
                    end
                end
                p_hs_noeof = !bus.out_eof;
            end
            p_valid = bus.out_valid;
            p_ready = bus.out_ready;
            p_sof   = bus.out_sof;
            p_eof   = bus.out_eof;
            p_byte  = bus.out_byte;
        end
    end

    task automatic test_reset();
        reset             = 1'b1;
        bus.in_addr       = '0;
        bus.in_buysell    = '0;
        bus.in_timestamp  = '0;
        bus.in_dv         = 1'b0;
        bus.out_ready     = 1'b0;
        bus2.in_addr      = '0;
        bus2.in_buysell   = '0;
        bus2.in_timestamp = '0;
        bus2.in_dv        = 1'b0;
        bus2.out_ready    = 1'b0;
        repeat (3) step();
        sample();
        checks++;
        if ({bus.out_valid, bus.out_sof, bus.out_eof, bus.busy, bus.fifo_full} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {bus.out_valid, bus.out_sof, bus.out_eof, bus.busy, bus.fifo_full});
        end
        checks++;
        if (bus.out_byte !== 8'h00 || bus.drop_count !== 16'h0 || bus2.drop_count !== 2'b00) begin
            errors++;
            $display("FAIL reset_values got byte=%h drop=%h drop_sat=%h want 00 0000 0",
                     bus.out_byte, bus.drop_count, bus2.drop_count);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        int hs0;
        int gaps;
        hs0 = hs_cnt;
        gaps = 0;
        bus.out_ready = 1'b1;
        step();
        drive_order(8'h03, 8'h01, 32'h1234_5678);
        exp_q.push_back(10'h2A5);
        exp_q.push_back(10'h003);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h012);
        exp_q.push_back(10'h034);
        exp_q.push_back(10'h056);
        exp_q.push_back(10'h078);
        exp_q.push_back(10'h10A);
        step();
        bus.in_dv = 1'b0;
        sample();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got valid=%b want 0 at N+1", bus.out_valid);
        end
        sample();
        checks++;
        if ({bus.out_valid, bus.out_sof, bus.busy, bus.out_byte} !== {3'b111, 8'hA5}) begin
            errors++;
            $display("FAIL latency_first got v=%b sof=%b busy=%b byte=%h want 1 1 1 a5 at N+2",
                     bus.out_valid, bus.out_sof, bus.busy, bus.out_byte);
        end
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            sample();
            if (!bus.out_valid) gaps++;
        end
        checks++;
        if (exp_q.size() != 0 || (hs_cnt - hs0) != 8 || gaps != 0) begin
            errors++;
            $display("FAIL single_frame got left=%0d hs=%0d gaps=%0d want 0 8 0",
                     exp_q.size(), hs_cnt - hs0, gaps);
        end
        sample();
        checks++;
        if ({bus.busy, bus.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle got busy=%b valid=%b want 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_stall();
        int hs0;
        hs0 = hs_cnt;
        step();
        drive_order(8'hC4, 8'h02, 32'hDEAD_BEEF);
        push_order(8'hC4, 8'h02, 32'hDEAD_BEEF);
        step();
        bus.in_dv = 1'b0;
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            step();
            bus.out_ready = (c % 2 == 0);
        end
        checks++;
        if (exp_q.size() != 0 || (hs_cnt - hs0) != 8) begin
            errors++;
            $display("FAIL stall_frame got left=%0d hs=%0d want 0 8", exp_q.size(), hs_cnt - hs0);
        end
        bus.out_ready = 1'b1;
        sample();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_burst_full();
        int hs0;
        int gaps;
        int inj;
        int w;
        logic [7:0]  a;
        logic [31:0] ts;
        hs0 = hs_cnt;
        gaps = 0;
        inj = -1;
        w = 0;
        bus.out_ready = 1'b0;
        step();
        drive_order(8'h11, 8'h01, 32'hA000_0000);
        push_order(8'h11, 8'h01, 32'hA000_0000);
        step();
        bus.in_dv = 1'b0;
        // First order parks in the framer stalled, so the burst lands wholly in the FIFO.
        while (!bus.out_valid && w < 10) begin
            sample();
            w++;
        end
        checks++;
        if ({bus.out_valid, bus.out_sof} !== 2'b11) begin
            errors++;
            $display("FAIL burst_parked got v=%b sof=%b want 1 1", bus.out_valid, bus.out_sof);
        end
        for (int k = 0; k < 10; k++) begin
            a  = 8'h20 + 8'(k);
            ts = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
            drive_order(a, 8'h02, ts);
            if (k < 8) push_order(a, 8'h02, ts);
            step();
        end
        bus.in_dv = 1'b0;
        sample();
        checks++;
        if ({bus.fifo_full, bus.busy, bus.out_valid} !== 3'b111 || bus.drop_count !== 16'd2) begin
            errors++;
            $display("FAIL burst_overflow got full=%b busy=%b v=%b drop=%0d want 1 1 1 2",
                     bus.fifo_full, bus.busy, bus.out_valid, bus.drop_count);
        end
        step();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
            sample();
            if (!bus.out_valid) gaps++;
            if (inj >= 0 && c == inj + 1) begin
                bus.in_dv = 1'b0;
                checks++;
                if (bus.fifo_full !== 1'b1 || bus.drop_count !== 16'd2) begin
                    errors++;
                    $display("FAIL full_reload_write got full=%b drop=%0d want 1 2",
                             bus.fifo_full, bus.drop_count);
                end
            end
            if (inj < 0 && bus.out_valid && bus.out_eof) begin
                drive_order(8'h77, 8'h02, 32'h0BAD_F00D);
                push_order(8'h77, 8'h02, 32'h0BAD_F00D);
                inj = c;
            end
        end
        checks++;
        if (exp_q.size() != 0 || (hs_cnt - hs0) != 80 || gaps != 0 || inj < 0) begin
            errors++;
            $display("FAIL burst_drain got left=%0d hs=%0d gaps=%0d inj=%0d want 0 80 0 >=0",
                     exp_q.size(), hs_cnt - hs0, gaps, inj);
        end
        sample();
        checks++;
        if ({bus.busy, bus.fifo_full, bus.out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL burst_idle got busy=%b full=%b v=%b want 0 0 0",
                     bus.busy, bus.fifo_full, bus.out_valid);
        end
    endtask

    task automatic test_reset_midframe();
        int hs0;
        bus.out_ready = 1'b1;
        hs0 = hs_cnt;
        for (int k = 0; k < 4; k++) begin
            drive_order(8'h40 + 8'(k), 8'h01, 32'h5555_0000 + 32'(k));
            push_order(8'h40 + 8'(k), 8'h01, 32'h5555_0000 + 32'(k));
            step();
        end
        bus.in_dv = 1'b0;
        for (int w = 0; w < 40 && (hs_cnt - hs0) < 4; w++) sample();
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ((hs_cnt - hs0) != 4 || {bus.out_valid, bus.out_sof, bus.out_eof, bus.busy, bus.fifo_full} !== 5'b0 ||
            bus.drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_abort got hs=%0d flags=%b drop=%0d want 4 00000 0",
                     hs_cnt - hs0, {bus.out_valid, bus.out_sof, bus.out_eof, bus.busy, bus.fifo_full},
                     bus.drop_count);
        end
        exp_q.delete();
        repeat (2) step();
        reset = 1'b0;
        sample();
        sample();
        checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flushed got v=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
        hs0 = hs_cnt;
        step();
        drive_order(8'h5A, 8'h01, 32'h0000_0001);
        push_order(8'h5A, 8'h01, 32'h0000_0001);
        step();
        bus.in_dv = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) sample();
        checks++;
        if (exp_q.size() != 0 || (hs_cnt - hs0) != 8) begin
            errors++;
            $display("FAIL reset_new_frame got left=%0d hs=%0d want 0 8", exp_q.size(), hs_cnt - hs0);
        end
    endtask

    task automatic test_drop_saturate();
        step();
        for (int k = 1; k <= 15; k++) begin
            bus2.in_addr      = 8'(k);
            bus2.in_buysell   = 8'h01;
            bus2.in_timestamp = 32'(k);
            bus2.in_dv        = 1'b1;
            step();
            if (k == 9 || k == 11) begin
                sample();
                checks++;
                if (bus2.fifo_full !== 1'b1 || bus2.drop_count !== ((k == 9) ? 2'd0 : 2'd2)) begin
                    errors++;
                    $display("FAIL drop_count_k%0d got full=%b drop=%0d want 1 %0d",
                             k, bus2.fifo_full, bus2.drop_count, (k == 9) ? 0 : 2);
                end
            end
        end
        bus2.in_dv = 1'b0;
        sample();
        checks++;
        if (bus2.drop_count !== 2'd3 || bus2.fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL drop_saturate got drop=%0d full=%b want 3 1", bus2.drop_count, bus2.fifo_full);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_burst_full();
        test_reset_midframe();
        test_drop_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
